// File: rtl/axis_framer.sv
// AXI-Stream framer: 2-entry registered skid buffer, TLAST every FRAME_LEN beats, frame counter.
// Define AXIS_FRAMER_CHECKSUM_EN to append an XOR checksum beat to each frame.
module axis_framer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned FRAME_LEN  = 2
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  output logic                  M_AXIS_TLAST,
  input  logic                  M_AXIS_TREADY,
  output logic [15:0]           FRAME_CNT
);
  localparam logic [15:0] LAST_IDX = 16'(FRAME_LEN - 1);

  logic [DATA_WIDTH-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
  logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic                  skid_valid_q, skid_valid_d, skid_last_q, skid_last_d;
  logic                  s_ready_q, s_ready_d;
  logic [15:0]           beat_q, beat_d, frame_q, frame_d;
  logic                  in_fire, m_fire, frame_end;
  logic                  push, push_last, data_next;
  logic [DATA_WIDTH-1:0] push_data;

  assign in_fire   = S_AXIS_TVALID & s_ready_q;
  assign m_fire    = out_valid_q & M_AXIS_TREADY;
  assign frame_end = (beat_q == LAST_IDX);

`ifdef AXIS_FRAMER_CHECKSUM_EN
  typedef enum logic {ST_DATA, ST_CSUM} state_e;
  state_e                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic                  csum_push;

  // The checksum beat competes for buffer space exactly like an input beat.
  assign csum_push = (state_q == ST_CSUM) & ~skid_valid_q;

  always_comb begin
    push      = in_fire | csum_push;
    push_data = csum_push ? acc_q : S_AXIS_TDATA;
    push_last = csum_push;
    data_next = (state_q == ST_DATA) ? !(in_fire && frame_end) : csum_push;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_DATA;
      acc_q   <= '0;
    end else begin
      if (in_fire)
        acc_q <= (beat_q == '0) ? S_AXIS_TDATA : (acc_q ^ S_AXIS_TDATA);
      case (state_q)
        ST_DATA: if (in_fire && frame_end) state_q <= ST_CSUM;
        ST_CSUM: if (csum_push) state_q <= ST_DATA;
        default: state_q <= ST_DATA;
      endcase
    end
  end
`else
  always_comb begin
    push      = in_fire;
    push_data = S_AXIS_TDATA;
    push_last = frame_end;
    data_next = 1'b1;
  end
`endif

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || m_fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) begin
          out_data_d = push_data;
          out_last_d = push_last;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = push_data;
      skid_last_d  = push_last;
    end
    beat_d = beat_q;
    if (in_fire) beat_d = frame_end ? '0 : beat_q + 16'd1;
    frame_d   = (m_fire && out_last_q) ? frame_q + 16'd1 : frame_q;
    // Ready mirrors next-cycle skid occupancy so it can be a plain register.
    s_ready_d = !skid_valid_d && data_next;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      s_ready_q    <= 1'b0;
      beat_q       <= '0;
      frame_q      <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      s_ready_q    <= s_ready_d;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TDATA  = out_data_q;
  assign M_AXIS_TVALID = out_valid_q;
  assign M_AXIS_TLAST  = out_last_q;
  assign FRAME_CNT     = frame_q;

endmodule

// File: doc/axis_framer.md
AXIS_FRAMER -- requirements
Module: axis_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the stream data width in bits on both ports.
REQ-002 SHALL have parameter FRAME_LEN, default 2, the number of payload beats per frame; legal range 1..65535.
REQ-003 SHALL have port ACLK, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port ARESET, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port S_AXIS_TDATA, input, DATA_WIDTH, unframed payload in.
REQ-006 SHALL have port S_AXIS_TVALID, input, 1, upstream data valid.
REQ-007 SHALL have port S_AXIS_TREADY, output, 1, framer can accept a beat.
REQ-008 SHALL have port M_AXIS_TDATA, output, DATA_WIDTH, framed data out, feeding the downstream processing IP's slave stream.
REQ-009 SHALL have port M_AXIS_TVALID, output, 1, output beat valid.
REQ-010 SHALL have port M_AXIS_TLAST, output, 1, marks the final beat of a frame.
REQ-011 SHALL have port M_AXIS_TREADY, input, 1, downstream accepts a beat.
REQ-012 SHALL have port FRAME_CNT, output, 16, count of completed frames.

Function
REQ-013 SHALL transfer a beat on a port only in a cycle where TVALID and TREADY are both high.
REQ-014 SHALL buffer beats in a 2-entry skid buffer; every output (S_AXIS_TREADY, M_AXIS_*) SHALL be driven from registers.
REQ-015 SHALL assert M_AXIS_TVALID exactly 1 cycle after the first input beat is accepted into an empty buffer.
REQ-016 SHALL sustain 1 beat/cycle when M_AXIS_TREADY is held high; without CHECKSUM_EN it SHALL never insert bubbles.
REQ-017 SHALL deassert S_AXIS_TREADY in the cycle after the buffer reaches 2 entries; it SHALL reassert in the cycle after an entry drains; no beat SHALL be lost or duplicated.
REQ-018 SHALL hold M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TVALID stable while M_AXIS_TVALID=1 and M_AXIS_TREADY=0.
REQ-019 SHALL keep a payload beat counter, 0..FRAME_LEN-1, that increments per accepted input beat and wraps to 0 after FRAME_LEN-1.
REQ-020 SHALL tag the beat taken at counter value FRAME_LEN-1 as the frame end; with FRAME_LEN=1 every beat SHALL be a frame end.
REQ-021 SHALL increment FRAME_CNT when a beat with M_AXIS_TLAST=1 is accepted downstream; FRAME_CNT SHALL wrap 0xFFFF->0x0000.
REQ-022 SHALL treat S_AXIS_TVALID dropping mid-frame as a pause; the frame SHALL resume with the next accepted beat and the counter unchanged.
REQ-023 SHALL apply TDATA to the output unmodified; X/unused input data while S_AXIS_TVALID=0 SHALL never enter the buffer.

Reset
REQ-024 SHALL, while ARESET=1 at a clock edge, clear the buffer, the beat counter and FRAME_CNT; the state SHALL be DATA.
REQ-025 SHALL drive these outputs during and after reset until the first input is accepted: M_AXIS_TVALID=0, M_AXIS_TLAST=0, M_AXIS_TDATA=0, FRAME_CNT=0.
REQ-026 SHALL drive S_AXIS_TREADY=0 while ARESET=1 and 1 from the first cycle after reset is released.
REQ-027 SHALL, on a reset asserted mid-frame, discard any partial frame; the next frame SHALL start at beat 0.

Configuration
REQ-028 SHALL support macro AXIS_FRAMER_CHECKSUM_EN.
REQ-029 SHALL, with AXIS_FRAMER_CHECKSUM_EN defined, append one beat per frame after the FRAME_LEN payload beats. That beat SHALL be the bitwise XOR of the frame's payload words. It SHALL be the only beat with TLAST=1.
REQ-030 SHALL, with AXIS_FRAMER_CHECKSUM_EN defined, use a 2-state FSM (DATA, CSUM). DATA->CSUM SHALL occur on the accept of the last payload beat. CSUM->DATA SHALL occur when the checksum beat enters the buffer.
REQ-031 SHALL, in state CSUM, hold S_AXIS_TREADY=0; the checksum accumulator SHALL clear when the next frame starts.
REQ-032 SHALL, without AXIS_FRAMER_CHECKSUM_EN, contain no FSM and no accumulator; the last payload beat SHALL carry TLAST.

Verification
REQ-033 SHALL test reset: ARESET=1 for 2 cycles -> M_AXIS_TVALID=0, FRAME_CNT=0, S_AXIS_TREADY=0; after release, S_AXIS_TREADY=1 next cycle.
REQ-034 SHALL test a basic frame: FRAME_LEN=2, TREADY=1, inputs 0x0000FE40 then 0x00046000 -> two outputs 1 cycle later; TLAST only on 0x00046000; FRAME_CNT=1.
REQ-035 SHALL test backpressure: M_AXIS_TREADY=0 for 5 cycles during a 6-word burst -> S_AXIS_TREADY falls after 2 beats buffered; output order matches input; no drops.
REQ-036 SHALL test the checksum: with CHECKSUM_EN and FRAME_LEN=2, inputs 0x0000FE40, 0x00046000 -> third beat 0x00049E40 with TLAST=1; input stalls 1 cycle.
REQ-037 SHALL test mid-frame reset: reset after beat 1 of 2 -> next input 0xA5 is beat 0; TLAST on the following beat.
REQ-038 SHALL test wrap: FRAME_LEN=1, 65536 beats -> FRAME_CNT returns to 0x0000.
